// File: rtl/uart_word_rx.sv
// 16x-oversampling UART receiver with parity/framing checks that packs bytes
// LSB-first into N_BYTES_WORD-byte words delivered over a valid/ready handshake.
module uart_word_rx #(
    parameter int unsigned CLK          = 20_000_000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned N_DATA_BITS  = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned N_STOP       = 1,
    parameter int unsigned N_BYTES_WORD = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rx_data_i,
    input  logic                      flush_i,
    input  logic                      word_ready_i,
    output logic [8*N_BYTES_WORD-1:0] word_o,
    output logic                      word_valid_o,
    output logic [3:0]                byte_count_o,
    output logic                      parity_err_o,
    output logic                      framing_err_o,
    output logic                      overrun_o
);

    localparam int unsigned     DIV       = (CLK + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int unsigned     DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [2:0]      LAST_DATA = 3'(N_DATA_BITS - 1);
    localparam logic [2:0]      LAST_STOP = 3'(N_STOP - 1);
    localparam logic [3:0]      LAST_SLOT = 4'(N_BYTES_WORD - 1);
    localparam int unsigned     WW        = 8 * N_BYTES_WORD;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       sync_q, sync_d;
    logic [1:0]       vld_q, vld_d;
    logic             armed_q, armed_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_bad_q, par_bad_d;
    logic             stop_bad_q, stop_bad_d;
    logic [3:0]       byte_cnt_q, byte_cnt_d;
    logic [WW-1:0]    part_q, part_d;
    logic [WW-1:0]    word_q, word_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    logic             tick;
    logic             rx_s;
    logic [7:0]       data_byte;
    logic             byte_done;
    logic             frame_bad;
    logic [WW-1:0]    filled;

    assign tick      = (div_cnt_q == DIV_LAST);
    assign rx_s      = sync_q[1];
    assign data_byte = shift_q >> (8 - N_DATA_BITS);
    assign div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    assign sync_d    = {sync_q[0], rx_data_i};
    // The start detector stays disarmed until a genuine (post-synchroniser) high is seen.
    assign vld_d     = {vld_q[0], 1'b1};
    assign armed_d   = armed_q | (vld_q[1] & rx_s);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && !rx_s) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d   = {rx_s, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != 0) ? PAR : STOP;
                        end
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        par_bad_d = (PARITY == 1) ? ~(^data_byte ^ rx_s) : (^data_byte ^ rx_s);
                        state_d   = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        stop_bad_d = stop_bad_q | ~rx_s;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_STOP) begin
                            byte_done = 1'b1;
                            frame_bad = stop_bad_q | ~rx_s;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        part_d     = part_q;
        word_d     = word_q;
        valid_d    = valid_q & ~word_ready_i;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        filled     = part_q;
        for (int unsigned k = 0; k < N_BYTES_WORD; k++) begin
            if (byte_cnt_q == 4'(k)) filled[8*k +: 8] = data_byte;
        end
        // Flush outranks a coincident byte completion: the byte vanishes silently.
        if (flush_i) begin
            byte_cnt_d = '0;
            part_d     = '0;
        end else if (byte_done) begin
            if (par_bad_q || frame_bad) begin
                perr_d     = par_bad_q;
                ferr_d     = frame_bad;
                byte_cnt_d = '0;
                part_d     = '0;
            end else if (byte_cnt_q == LAST_SLOT) begin
                byte_cnt_d = '0;
                part_d     = '0;
                if (!valid_q || word_ready_i) begin
                    word_d  = filled;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                byte_cnt_d = byte_cnt_q + 4'd1;
                part_d     = filled;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            sync_q     <= '1;
            vld_q      <= '0;
            armed_q    <= 1'b0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            byte_cnt_q <= '0;
            part_q     <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            sync_q     <= sync_d;
            vld_q      <= vld_d;
            armed_q    <= armed_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            byte_cnt_q <= byte_cnt_d;
            part_q     <= part_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign word_o        = word_q;
    assign word_valid_o  = valid_q;
    assign byte_count_o  = byte_cnt_q;
    assign parity_err_o  = perr_q;
    assign framing_err_o = ferr_q;
    assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: 8N1 word path, even parity, two stop bits,
// overrun, flush, glitch rejection and mid-frame reset.
module tb_uart_word_rx;

    localparam int BIT_CLKS = 176;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  rx;
    logic        flush0, ready0;
    logic        flush_off = 1'b0;
    logic        ready_on  = 1'b1;
    logic [31:0] word0, word1, word2;
    logic        valid0, valid1, valid2;
    logic [3:0]  bc0, bc1, bc2;
    logic        perr0, perr1, perr2, ferr0, ferr1, ferr2, ovr0, ovr1, ovr2;

    int          vectors     = 0;
    int          miscompares = 0;
    int          perr_cnt[3] = '{0, 0, 0};
    int          ferr_cnt[3] = '{0, 0, 0};
    int          ovr_cnt[3]  = '{0, 0, 0};
    int          acc_cnt     = 0;
    logic [31:0] last_word   = '0;

    always #5 clock = ~clock;

    uart_word_rx dut0 (
        .clock(clock), .reset(reset_n), .rx_data_i(rx[0]), .flush_i(flush0),
        .word_ready_i(ready0), .word_o(word0), .word_valid_o(valid0),
        .byte_count_o(bc0), .parity_err_o(perr0), .framing_err_o(ferr0), .overrun_o(ovr0)
    );

    uart_word_rx #(.PARITY(2)) dut1 (
        .clock(clock), .reset(reset_n), .rx_data_i(rx[1]), .flush_i(flush_off),
        .word_ready_i(ready_on), .word_o(word1), .word_valid_o(valid1),
        .byte_count_o(bc1), .parity_err_o(perr1), .framing_err_o(ferr1), .overrun_o(ovr1)
    );

    uart_word_rx #(.N_STOP(2)) dut2 (
        .clock(clock), .reset(reset_n), .rx_data_i(rx[2]), .flush_i(flush_off),
        .word_ready_i(ready_on), .word_o(word2), .word_valid_o(valid2),
        .byte_count_o(bc2), .parity_err_o(perr2), .framing_err_o(ferr2), .overrun_o(ovr2)
    );

    always @(negedge clock) begin
        if (perr0) perr_cnt[0]++;
        if (perr1) perr_cnt[1]++;
        if (perr2) perr_cnt[2]++;
        if (ferr0) ferr_cnt[0]++;
        if (ferr1) ferr_cnt[1]++;
        if (ferr2) ferr_cnt[2]++;
        if (ovr0)  ovr_cnt[0]++;
        if (ovr1)  ovr_cnt[1]++;
        if (ovr2)  ovr_cnt[2]++;
        if (valid0 && ready0) begin
            acc_cnt++;
            last_word = word0;
        end
    end

    task automatic wait_bit();
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    // par_mode: 0 none, 1 odd, 2 even. A low final stop bit is held only past its sample point.
    task automatic send_frame(input int idx, input logic [7:0] data, input int par_mode,
                              input bit flip_par, input int nstop, input bit low_last_stop);
        logic p;
        rx[idx] = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx[idx] = data[i];
            wait_bit();
        end
        if (par_mode != 0) begin
            p = ^data;
            if (par_mode == 1) p = ~p;
            if (flip_par) p = ~p;
            rx[idx] = p;
            wait_bit();
        end
        for (int s = 0; s < nstop; s++) begin
            if (low_last_stop && s == nstop - 1) begin
                rx[idx] = 1'b0;
                repeat (120) @(negedge clock);
                rx[idx] = 1'b1;
                repeat (BIT_CLKS - 120) @(negedge clock);
            end else begin
                rx[idx] = 1'b1;
                wait_bit();
            end
        end
        rx[idx] = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx      = 3'b111;
        flush0  = 1'b0;
        ready0  = 1'b1;
        repeat (4) @(negedge clock);
        vectors++; if (word0 !== 32'h0) begin miscompares++; $display("FAIL reset_word: got %h expected %h", word0, 32'h0); end
        vectors++; if (valid0 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid0); end
        vectors++; if (bc0 !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", bc0); end
        vectors++; if ({perr0, ferr0, ovr0} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses: got %b expected 000", {perr0, ferr0, ovr0}); end
        vectors++; if ({valid1, bc1, valid2, bc2} !== 10'd0) begin miscompares++; $display("FAIL reset_other: got %h expected 0", {valid1, bc1, valid2, bc2}); end
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_word();
        logic [7:0] bytes [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        logic [3:0] exp_bc[4] = '{4'd1, 4'd2, 4'd3, 4'd0};
        int acc0 = acc_cnt;
        ready0 = 1'b1;
        for (int b = 0; b < 4; b++) begin
            send_frame(0, bytes[b], 0, 1'b0, 1, 1'b0);
            vectors++; if (bc0 !== exp_bc[b]) begin miscompares++; $display("FAIL word_count_%0d: got %0d expected %0d", b, bc0, exp_bc[b]); end
        end
        vectors++; if (acc_cnt !== acc0 + 1) begin miscompares++; $display("FAIL word_pulses: got %0d expected %0d", acc_cnt - acc0, 1); end
        vectors++; if (last_word !== 32'h12345678) begin miscompares++; $display("FAIL word_value: got %h expected %h", last_word, 32'h12345678); end
        vectors++; if (valid0 !== 1'b0) begin miscompares++; $display("FAIL word_valid_cleared: got %b expected 0", valid0); end
    endtask

    task automatic test_parity();
        send_frame(1, 8'hA5, 2, 1'b0, 1, 1'b0);
        vectors++; if (bc1 !== 4'd1) begin miscompares++; $display("FAIL parity_good_count: got %0d expected 1", bc1); end
        vectors++; if (perr_cnt[1] !== 0) begin miscompares++; $display("FAIL parity_good_err: got %0d expected 0", perr_cnt[1]); end
        send_frame(1, 8'h01, 2, 1'b1, 1, 1'b0);
        vectors++; if (bc1 !== 4'd0) begin miscompares++; $display("FAIL parity_bad_count: got %0d expected 0", bc1); end
        vectors++; if (perr_cnt[1] !== 1) begin miscompares++; $display("FAIL parity_bad_err: got %0d expected 1", perr_cnt[1]); end
        vectors++; if (ferr_cnt[1] !== 0) begin miscompares++; $display("FAIL parity_no_ferr: got %0d expected 0", ferr_cnt[1]); end
    endtask

    task automatic test_framing();
        send_frame(2, 8'h3C, 0, 1'b0, 2, 1'b0);
        vectors++; if (bc2 !== 4'd1) begin miscompares++; $display("FAIL frame_good_count: got %0d expected 1", bc2); end
        send_frame(2, 8'h3C, 0, 1'b0, 2, 1'b1);
        vectors++; if (ferr_cnt[2] !== 1) begin miscompares++; $display("FAIL frame_err: got %0d expected 1", ferr_cnt[2]); end
        vectors++; if (bc2 !== 4'd0) begin miscompares++; $display("FAIL frame_count: got %0d expected 0", bc2); end
        wait_bit();
        vectors++; if ({bc2, perr_cnt[2]} !== {4'd0, 32'd0}) begin miscompares++; $display("FAIL frame_after: got count %0d perr %0d expected 0 0", bc2, perr_cnt[2]); end
    endtask

    task automatic test_overrun();
        logic [7:0] bytes [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h44, 8'h33, 8'h22, 8'h11};
        int ovr0_start = ovr_cnt[0];
        ready0 = 1'b0;
        for (int b = 0; b < 8; b++) begin
            send_frame(0, bytes[b], 0, 1'b0, 1, 1'b0);
            if (b == 3) begin
                vectors++; if (word0 !== 32'h12345678) begin miscompares++; $display("FAIL ovr_first_word: got %h expected %h", word0, 32'h12345678); end
                vectors++; if (valid0 !== 1'b1) begin miscompares++; $display("FAIL ovr_first_valid: got %b expected 1", valid0); end
            end
        end
        vectors++; if (ovr_cnt[0] !== ovr0_start + 1) begin miscompares++; $display("FAIL ovr_pulse: got %0d expected %0d", ovr_cnt[0] - ovr0_start, 1); end
        vectors++; if (word0 !== 32'h12345678) begin miscompares++; $display("FAIL ovr_word_held: got %h expected %h", word0, 32'h12345678); end
        vectors++; if ({valid0, bc0} !== {1'b1, 4'd0}) begin miscompares++; $display("FAIL ovr_state: got valid %b count %0d expected 1 0", valid0, bc0); end
        ready0 = 1'b1;
        @(negedge clock);
        ready0 = 1'b0;
        vectors++; if (valid0 !== 1'b0) begin miscompares++; $display("FAIL ovr_accept: got %b expected 0", valid0); end
    endtask

    task automatic test_flush();
        int acc0;
        ready0 = 1'b1;
        send_frame(0, 8'hAA, 0, 1'b0, 1, 1'b0);
        send_frame(0, 8'hBB, 0, 1'b0, 1, 1'b0);
        vectors++; if (bc0 !== 4'd2) begin miscompares++; $display("FAIL flush_pre_count: got %0d expected 2", bc0); end
        flush0 = 1'b1;
        @(negedge clock);
        flush0 = 1'b0;
        vectors++; if (bc0 !== 4'd0) begin miscompares++; $display("FAIL flush_count: got %0d expected 0", bc0); end
        acc0 = acc_cnt;
        for (int b = 1; b <= 4; b++) send_frame(0, 8'(b), 0, 1'b0, 1, 1'b0);
        vectors++; if (acc_cnt !== acc0 + 1) begin miscompares++; $display("FAIL flush_pulses: got %0d expected 1", acc_cnt - acc0); end
        vectors++; if (last_word !== 32'h04030201) begin miscompares++; $display("FAIL flush_word: got %h expected %h", last_word, 32'h04030201); end
    endtask

    task automatic test_glitch();
        int acc0 = acc_cnt;
        rx[0] = 1'b0;
        repeat (3) @(negedge clock);
        rx[0] = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clock);
        vectors++; if (bc0 !== 4'd0) begin miscompares++; $display("FAIL glitch_count: got %0d expected 0", bc0); end
        vectors++; if (acc_cnt !== acc0) begin miscompares++; $display("FAIL glitch_word: got %0d expected 0", acc_cnt - acc0); end
        vectors++; if (perr_cnt[0] + ferr_cnt[0] !== 0) begin miscompares++; $display("FAIL glitch_err: got %0d expected 0", perr_cnt[0] + ferr_cnt[0]); end
    endtask

    task automatic test_reset_midframe();
        int acc0;
        ready0 = 1'b0;
        send_frame(0, 8'h5A, 0, 1'b0, 1, 1'b0);
        vectors++; if (bc0 !== 4'd1) begin miscompares++; $display("FAIL rst_pre_count: got %0d expected 1", bc0); end
        rx[0] = 1'b0;
        wait_bit();
        rx[0] = 1'b0;
        wait_bit();
        rx[0] = 1'b1;
        repeat (40) @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        vectors++; if ({word0, valid0, bc0} !== 37'd0) begin miscompares++; $display("FAIL rst_outputs: got word %h valid %b count %0d expected 0", word0, valid0, bc0); end
        vectors++; if ({perr0, ferr0, ovr0} !== 3'b000) begin miscompares++; $display("FAIL rst_pulses: got %b expected 000", {perr0, ferr0, ovr0}); end
        reset_n = 1'b1;
        ready0  = 1'b1;
        repeat (BIT_CLKS) @(negedge clock);
        acc0 = acc_cnt;
        for (int b = 1; b <= 4; b++) send_frame(0, 8'(b * 17), 0, 1'b0, 1, 1'b0);
        vectors++; if (acc_cnt !== acc0 + 1) begin miscompares++; $display("FAIL rst_after_pulses: got %0d expected 1", acc_cnt - acc0); end
        vectors++; if (last_word !== 32'h44332211) begin miscompares++; $display("FAIL rst_after_word: got %h expected %h", last_word, 32'h44332211); end
        vectors++; if (perr_cnt[0] + ferr_cnt[0] !== 0) begin miscompares++; $display("FAIL dut0_errors: got %0d expected 0", perr_cnt[0] + ferr_cnt[0]); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_parity();
        test_framing();
        test_overrun();
        test_flush();
        test_glitch();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Parametrised UART receiver for the MIPS debug/loader path. It oversamples the serial line 16x and decodes configurable frames: 5–8 data bits, optional odd/even parity, 1 or 2 stop bits. Received bytes are assembled LSB-first into words of N_BYTES_WORD bytes and delivered over a valid/ready handshake. It generalises the current fixed 8N1 byte receiver: it checks parity and framing, reports overrun, and accepts a flush to resynchronise the loader's word stream.

## Interface
Parameters:
- CLK, 20E6, clock frequency in Hz.
- BAUD_RATE, 115200, line rate.
- N_DATA_BITS, 8, data bits per frame, 5..8.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- N_STOP, 1, stop bits, 1 or 2.
- N_BYTES_WORD, 4, bytes per output word, 1..8.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- rx_data_i  in  1  serial line; idle high; asynchronous to clock.
- flush_i  in  1  discards any partially assembled word.
- word_ready_i  in  1  consumer accepts word_o.
- word_o  out  8*N_BYTES_WORD  assembled word; byte k occupies bits [8k+7:8k].
- word_valid_o  out  1  word_o is valid.
- byte_count_o  out  4  bytes held in the partial word, 0..N_BYTES_WORD-1.
- parity_err_o  out  1  one-cycle pulse on a parity mismatch.
- framing_err_o  out  1  one-cycle pulse when a stop bit is sampled low.
- overrun_o  out  1  one-cycle pulse when a completed word is dropped.

## Operation
- **Tick generator:** DIV = (CLK + 8*BAUD_RATE) / (16*BAUD_RATE), computed with integer rounding. With the defaults this is 11. A free-running counter emits a one-cycle tick every DIV clocks.
- **Input synchroniser:** rx_data_i passes through a 2-FF synchroniser that resets to 1. Only the synchronised value is sampled.
- **State machine:** IDLE, START, DATA, PAR, STOP, with a 4-bit tick counter and a 3-bit bit counter.
  - IDLE: a synchronised low moves to START and clears the tick counter.
  - START: after 8 ticks (mid-bit), if the line is high it is treated as a glitch and returns to IDLE with no error. If low, it moves to DATA.
  - DATA: one sample every 16 ticks, shifted in LSB-first. After N_DATA_BITS samples it goes to PAR if PARITY≠0, otherwise to STOP.
  - PAR: one sample after 16 ticks. Parity is computed as the XOR of the data bits and the parity bit. Odd parity requires the result to be 1; even parity requires 0.
  - STOP: N_STOP samples at 16-tick spacing. A low on any stop sample is a framing error. After the last stop sample it returns to IDLE.
- **Byte completion:** happens at the final stop sample.
  - Good byte: written, zero-extended to 8 bits, into slot byte_count_o, and byte_count_o increments.
  - Parity or framing error: the byte is discarded, the matching error pulse is raised (both can pulse in the same cycle), and byte_count_o is cleared to 0.
- **Word completion:** when the good byte fills slot N_BYTES_WORD-1, byte_count_o wraps to 0.
  - If word_valid_o is 0, or word_ready_i is 1 in that cycle, the word loads into word_o and word_valid_o is set.
  - Otherwise the new word is dropped, word_o keeps the old word, and overrun_o pulses.
- **Handshake:** word_valid_o clears on the cycle after word_valid_o & word_ready_i, unless a new word loads in that same cycle. word_o holds stable while valid and not yet accepted.
- **Flush:** flush_i clears byte_count_o and the partial word. It does not affect word_o/word_valid_o or an in-flight frame.
  - If flush_i coincides with a byte completion, flush wins and that byte is discarded without an error pulse.
- **Reset (reset=0):** all outputs are 0, the FSM returns to IDLE, and the counters and synchroniser are reset. A frame in progress is abandoned. After reset release, a line that is already low is not treated as a start bit until it has been seen high.

## Timing
- One bit period is 16*DIV clocks; 176 with the defaults.
- A start edge is recognised 2–3 clocks after rx_data_i falls, because of the synchroniser.
- word_valid_o rises 1 clock after the final stop-bit sample of the last byte.
- Error and overrun pulses occur in the same cycle as the byte/word completion they refer to.
- Back-to-back frames with zero idle time are supported. The FSM re-enters IDLE before the next start edge is sampled.
- A byte completion and a handshake acceptance in the same cycle are both honoured.

## Test plan
- Defaults (8N1, 4 bytes): send bytes 0x78, 0x56, 0x34, 0x12 with word_ready_i=1 → one word_o=0x12345678 valid pulse; byte_count_o steps 1, 2, 3, 0; no error pulses.
- PARITY=2 (even): send 0xA5 with the correct parity bit, then 0x01 with the parity bit forced to 0 → the first byte is accepted (byte_count_o=1); the second gives a parity_err_o pulse and byte_count_o=0.
- N_STOP=2: send 0x3C with the second stop bit driven low → framing_err_o pulses; the byte is discarded.
- Hold word_ready_i=0 and send 8 bytes → the first word_o=0x12345678 stays held; overrun_o pulses at the 8th byte; word_o is unchanged after 0x44 0x33 0x22 0x11.
- Send 2 bytes, assert flush_i for 1 clock, then send 4 bytes → word_o equals the 4 bytes received after the flush.
- A 3-clock low glitch on rx_data_i gives no byte and no error. Asserting reset=0 mid-frame gives all outputs 0, and the next clean frame is received correctly.
